// File: rtl/cart_rom_fetch.sv
// Cartridge ROM fetch buffer: serves mapper byte reads from a one-word
// demand buffer plus a one-word speculative next-word prefetch buffer.
//
// Ports:
//   clk_sys, reset_n         system clock, async active-low reset
//   pclk0, pclk1             CPU phase enables (lookups use pclk1)
//   rom_address, cart_read   mapper byte address and read qualifier
//   flush                    drop all buffered data
//   rom_din, rom_ready       byte returned to the mapper and its valid flag
//   mem_addr, mem_req        word read request to the SDRAM arbiter
//   mem_ack, mem_rdata       one-cycle acknowledge with read data
//   miss_count               saturating demand miss counter
module cart_rom_fetch #(
   parameter bit PREFETCH_EN = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        pclk0,
   input  logic        pclk1,
   input  logic [24:0] rom_address,
   input  logic        cart_read,
   input  logic        flush,
   output logic [7:0]  rom_din,
   output logic        rom_ready,
   output logic [23:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] miss_count
);

   typedef enum logic [1:0] {IDLE, DREQ, PREQ} state_t;

   state_t      state;
   logic        d_valid;
   logic [23:0] d_tag;
   logic [15:0] d_data;
   logic        p_valid;
   logic [23:0] p_tag;
   logic [15:0] p_data;
   logic        dq;
   logic [23:0] q_tag;
   logic        q_sel;
   logic        disc;

   logic [23:0] tag;
   logic [23:0] nxt_tag;
   logic        look;
   logic        d_hit;
   logic        p_hit;
   logic        pf_go;
   logic        ack_ok;
   logic        unused_pclk0;

   function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
      return hi ? w[15:8] : w[7:0];
   endfunction

   assign unused_pclk0 = pclk0;
   assign tag     = rom_address[24:1];
   assign nxt_tag = d_tag + 24'd1;
   // A queued or outstanding demand means the mapper is still waiting
   // on the same address, so further lookups are ignored.
   assign look    = pclk1 & cart_read & ~dq & (state != DREQ);
   assign d_hit   = d_valid & (d_tag == tag);
   assign p_hit   = p_valid & (p_tag == tag);
   assign pf_go   = PREFETCH_EN & d_valid & ~p_valid & (p_tag != nxt_tag);
   // Data of a request overlapped by a flush is never used.
   assign ack_ok  = mem_ack & ~flush & ~disc;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         rom_din    <= 8'h00;
         rom_ready  <= 1'b0;
         d_valid    <= 1'b0;
         d_tag      <= '0;
         d_data     <= '0;
         p_valid    <= 1'b0;
         p_tag      <= '0;
         p_data     <= '0;
         dq         <= 1'b0;
         q_tag      <= '0;
         q_sel      <= 1'b0;
         disc       <= 1'b0;
         miss_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dq) begin
                  state    <= DREQ;
                  mem_req  <= 1'b1;
                  mem_addr <= q_tag;
                  dq       <= 1'b0;
               end else if (pf_go) begin
                  state    <= PREQ;
                  mem_req  <= 1'b1;
                  mem_addr <= nxt_tag;
               end
            end
            DREQ: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  if (ack_ok) begin
                     d_tag     <= mem_addr;
                     d_data    <= mem_rdata;
                     d_valid   <= 1'b1;
                     rom_din   <= pick(mem_rdata, q_sel);
                     rom_ready <= 1'b1;
                  end
               end
            end
            PREQ: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  if (ack_ok) begin
                     p_tag <= mem_addr;
                     // A demand that missed while this prefetch was in
                     // flight is served straight from the returning word.
                     if (dq && q_tag == mem_addr) begin
                        d_tag     <= mem_addr;
                        d_data    <= mem_rdata;
                        d_valid   <= 1'b1;
                        rom_din   <= pick(mem_rdata, q_sel);
                        rom_ready <= 1'b1;
                        dq        <= 1'b0;
                     end else begin
                        p_data  <= mem_rdata;
                        p_valid <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (mem_ack)
            disc <= 1'b0;
         else if (flush && (state != IDLE || (!dq && pf_go)))
            disc <= 1'b1;

         if (look) begin
            if (flush || !(d_hit || p_hit)) begin
               rom_ready <= 1'b0;
               dq        <= 1'b1;
               q_tag     <= tag;
               q_sel     <= rom_address[0];
               if (miss_count != 16'hFFFF)
                  miss_count <= miss_count + 16'd1;
            end else if (d_hit) begin
               rom_din   <= pick(d_data, rom_address[0]);
               rom_ready <= 1'b1;
            end else begin
               d_valid   <= 1'b1;
               d_tag     <= p_tag;
               d_data    <= p_data;
               p_valid   <= 1'b0;
               rom_din   <= pick(p_data, rom_address[0]);
               rom_ready <= 1'b1;
            end
         end

         if (flush) begin
            d_valid   <= 1'b0;
            p_valid   <= 1'b0;
            rom_ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Directed bench for cart_rom_fetch with a fixed-latency memory
// responder and hand-computed expected bytes.
module tb_cart_rom_fetch;

   localparam int LAT = 5;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        pclk0;
   logic        pclk1;
   logic [24:0] rom_address;
   logic        cart_read;
   logic        flush;
   logic [7:0]  rom_din;
   logic        rom_ready;
   logic [23:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] miss_count;

   int          n_checks = 0;
   int          n_err = 0;
   int          req_cnt = 0;
   logic [23:0] last_addr = '0;
   logic        flush_cmd = 1'b0;
   logic        flush_ack = 1'b0;
   logic        flush_on_ack = 1'b0;

   assign flush = flush_cmd | flush_ack;

   always #5 clk_sys = ~clk_sys;

   cart_rom_fetch #(.PREFETCH_EN(1'b1)) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .pclk0       (pclk0),
      .pclk1       (pclk1),
      .rom_address (rom_address),
      .cart_read   (cart_read),
      .flush       (flush),
      .rom_din     (rom_din),
      .rom_ready   (rom_ready),
      .mem_addr    (mem_addr),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .miss_count  (miss_count)
   );

   function automatic logic [15:0] mem_word(input logic [23:0] a);
      case (a)
         24'h00091A: return 16'hBEEF;
         24'h00091B: return 16'hCAFE;
         24'h00091C: return 16'h1357;
         24'hFFFFFF: return 16'hA55A;
         24'h000000: return 16'h0F0F;
         default:    return {a[7:0], ~a[7:0]};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic lookup(input logic [24:0] a);
      rom_address = a;
      cart_read   = 1'b1;
      pclk1       = 1'b1;
      @(negedge clk_sys);
      pclk1       = 1'b0;
      cart_read   = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (rom_ready !== 1'b1 && k < 40) begin
         @(negedge clk_sys);
         k++;
      end
      chk(tag, rom_ready, 1);
   endtask

   task automatic wait_req(input logic lvl, input string tag);
      int k = 0;
      while (mem_req !== lvl && k < 40) begin
         @(negedge clk_sys);
         k++;
      end
      chk(tag, mem_req, lvl);
   endtask

   // Memory responder: acks LAT cycles after a request is first seen.
   initial begin
      int cnt = 0;
      logic prev = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk_sys);
         if (mem_ack) begin
            mem_ack   = 1'b0;
            flush_ack = 1'b0;
         end else if (mem_req) begin
            if (!prev) begin
               req_cnt++;
               last_addr = mem_addr;
            end
            if (cnt == LAT) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_word(mem_addr);
               cnt       = 0;
               if (flush_on_ack) begin
                  flush_ack    = 1'b1;
                  flush_on_ack = 1'b0;
               end
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
         prev = mem_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      reset_n     = 1'b0;
      pclk0       = 1'b0;
      pclk1       = 1'b0;
      cart_read   = 1'b0;
      rom_address = '0;
      cycles(3);
      chk("rst_ready", rom_ready, 0);
      chk("rst_din", rom_din, 8'h00);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_miss", miss_count, 0);
      reset_n = 1'b1;
      cycles(1);

      // cold miss
      lookup(25'h0001235);
      chk("cold_ready0", rom_ready, 0);
      chk("cold_miss", miss_count, 1);
      wait_ready("cold_wait");
      chk("cold_din", rom_din, 8'hBE);
      chk("cold_addr", last_addr, 24'h00091A);
      chk("cold_reqs", req_cnt, 1);

      // demand hit, then prefetch of next word
      lookup(25'h0001234);
      chk("dhit_ready", rom_ready, 1);
      chk("dhit_din", rom_din, 8'hEF);
      chk("dhit_miss", miss_count, 1);
      cycles(20);
      chk("pf1_reqs", req_cnt, 2);
      chk("pf1_addr", last_addr, 24'h00091B);

      // prefetch hit
      lookup(25'h0001236);
      chk("phit_ready", rom_ready, 1);
      chk("phit_din", rom_din, 8'hFE);
      chk("phit_miss", miss_count, 1);
      cycles(20);
      chk("pf2_reqs", req_cnt, 3);
      chk("pf2_addr", last_addr, 24'h00091C);

      // flush, then wrap of prefetch address
      flush_cmd = 1'b1;
      cycles(1);
      flush_cmd = 1'b0;
      chk("flush_ready", rom_ready, 0);
      lookup(25'h1FFFFFF);
      chk("wrap_miss", miss_count, 2);
      wait_ready("wrap_wait");
      chk("wrap_din", rom_din, 8'hA5);
      cycles(20);
      chk("wrap_reqs", req_cnt, 5);
      chk("wrap_addr", last_addr, 24'h000000);
      lookup(25'h0000000);
      chk("wrap_hit", rom_ready, 1);
      chk("wrap_hdin", rom_din, 8'h0F);
      chk("wrap_hmiss", miss_count, 2);
      cycles(20);
      chk("wrap_reqs2", req_cnt, 6);

      // write cycle touches nothing
      rom_address = 25'h0001234;
      cart_read   = 1'b0;
      pclk1       = 1'b1;
      cycles(1);
      pclk1       = 1'b0;
      cycles(10);
      chk("wr_reqs", req_cnt, 6);
      chk("wr_miss", miss_count, 2);
      chk("wr_ready", rom_ready, 1);
      chk("wr_din", rom_din, 8'h0F);

      // flush coincident with demand ack
      flush_on_ack = 1'b1;
      lookup(25'h0000100);
      chk("fa_miss", miss_count, 3);
      cycles(15);
      chk("fa_ready", rom_ready, 0);
      chk("fa_reqs", req_cnt, 7);
      lookup(25'h0000100);
      chk("fa_remiss", miss_count, 4);
      wait_ready("fa_wait");
      chk("fa_din", rom_din, 8'h7F);
      chk("fa_reqs2", req_cnt, 8);

      // miss to the word being prefetched
      wait_req(1'b1, "pf81_start");
      chk("pf81_addr", mem_addr, 24'h000081);
      lookup(25'h0000102);
      chk("pm_ready0", rom_ready, 0);
      chk("pm_miss", miss_count, 5);
      wait_ready("pm_wait");
      chk("pm_din", rom_din, 8'h7E);

      // unrelated miss while a prefetch is outstanding
      wait_req(1'b1, "pf82_start");
      chk("pf82_addr", mem_addr, 24'h000082);
      lookup(25'h0000A55);
      chk("um_miss", miss_count, 6);
      wait_req(1'b0, "um_pfdone");
      k = 0;
      while (mem_req !== 1'b1 && k < 10) begin
         cycles(1);
         k++;
      end
      chk("um_gap", (k >= 1 && k <= 2), 1);
      chk("um_addr", mem_addr, 24'h00052A);
      wait_ready("um_wait");
      chk("um_din", rom_din, 8'h2A);
      cycles(20);
      chk("um_reqs", req_cnt, 11);

      // reset in the middle of a handshake
      lookup(25'h0000200);
      chk("rm_miss", miss_count, 7);
      wait_req(1'b1, "rm_start");
      cycles(2);
      reset_n = 1'b0;
      cycles(1);
      chk("rm_req", mem_req, 0);
      chk("rm_ready", rom_ready, 0);
      chk("rm_cnt", miss_count, 0);
      reset_n = 1'b1;
      cycles(10);
      chk("rm_reqs", req_cnt, 12);
      lookup(25'h0000200);
      chk("rm_miss2", miss_count, 1);
      wait_ready("rm_wait");
      chk("rm_din", rom_din, 8'hFF);
      chk("rm_reqs2", req_cnt, 13);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
